latch_byte_collector: RTL and testbench

LATCH_BYTE_COLLECTOR -- requirements
Module: latch_byte_collector

---
 rtl/latch_byte_collector.sv | 146 ++++++++++++++
 tb/tb_latch_byte_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_byte_collector.sv
// latch_byte_collector
//   Samples the output of an upstream D latch each time its enable closes
//   (en falls) and assembles WIDTH such samples, first sample in bit 0, into
//   a word that is handed downstream through a one-entry valid/ready buffer.
//   A word that completes while the buffer is still full is dropped and
//   recorded in a sticky overrun flag.
//
// Ports
//   clk        in   system clock, all state changes on its rising edge
//   reset      in   asynchronous active-low reset
//   en         in   latch enable driven to the upstream latch (clk-synchronous)
//   q          in   upstream latch output, stable while en is low
//   clr        in   synchronous clear of the partial word and overrun
//   byte_ready in   downstream accepts byte_data when byte_valid is also high
//   byte_data  out  assembled word (registered)
//   byte_valid out  byte_data holds an unconsumed word (registered)
//   bit_count  out  bits held in the partial word, 0..WIDTH-1 (registered)
//   overrun    out  sticky: a completed word was dropped (registered)
module latch_byte_collector #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       q,
  input  logic                       clr,
  input  logic                       byte_ready,
  output logic [WIDTH-1:0]           byte_data,
  output logic                       byte_valid,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       overrun
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic             en_q;
  // The partial word never holds more than WIDTH-1 bits; the WIDTH-th bit
  // is taken straight from q when the word completes.
  logic [WIDTH-2:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovr_q;

  logic             capture_s;
  logic             last_s;
  logic             load_s;
  logic             consume_s;
  logic [WIDTH-1:0] word_s;

  // Decode capture, completion and buffer handshake for the current cycle.
  always_comb begin
    capture_s = en_q & ~en;
    word_s    = {q, sr_q};
    consume_s = valid_q & byte_ready;
    if (state_q == ST_SHIFT) begin
      last_s = (cnt_q == CW'(WIDTH-1));
    end else begin
      last_s = 1'b0;
    end
    // A clr on the completing edge discards the word outright.
    if (capture_s && last_s && !clr) begin
      load_s = ~valid_q | byte_ready;
    end else begin
      load_s = 1'b0;
    end
  end

  // Collector FSM, shift register, output buffer and overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      en_q <= en;

      if (clr) begin
        state_q <= ST_IDLE;
        sr_q    <= '0;
        cnt_q   <= '0;
        ovr_q   <= 1'b0;
      end else if (capture_s) begin
        case (state_q)
          ST_IDLE: begin
            // WIDTH >= 2, so the first bit can never complete a word.
            state_q <= ST_SHIFT;
            sr_q    <= word_s[WIDTH-1:1];
            cnt_q   <= CW'(1);
          end
          ST_SHIFT: begin
            if (last_s) begin
              state_q <= ST_IDLE;
              sr_q    <= '0;
              cnt_q   <= '0;
              if (!load_s) begin
                ovr_q <= 1'b1;
              end else begin
                ovr_q <= ovr_q;
              end
            end else begin
              state_q <= ST_SHIFT;
              sr_q    <= word_s[WIDTH-1:1];
              cnt_q   <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
          end
        endcase
      end else begin
        state_q <= state_q;
        sr_q    <= sr_q;
        cnt_q   <= cnt_q;
      end

      // Output buffer: a completing word wins over a plain consumption.
      if (load_s) begin
        data_q  <= word_s;
        valid_q <= 1'b1;
      end else if (consume_s) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_q;
      end
    end
  end

  assign byte_data  = data_q;
  assign byte_valid = valid_q;
  assign bit_count  = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_latch_byte_collector.sv
// Testbench for latch_byte_collector (WIDTH=8): directed scenarios followed by
// random stimulus, all compared against a queue-based reference model.
module tb_latch_byte_collector;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         q = 1'b0;
  logic         clr = 1'b0;
  logic         byte_ready = 1'b0;
  logic [W-1:0] byte_data;
  logic         byte_valid;
  logic [3:0]   bit_count;
  logic         overrun;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit         m_enp;
  bit         m_bits[$];
  logic [7:0] m_data;
  bit         m_valid;
  bit         m_ovr;

  latch_byte_collector #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .q          (q),
    .clr        (clr),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .bit_count  (bit_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_enp   = 1'b0;
    m_bits.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // One rising edge of behaviour, from the rules: a fall of en captures q;
  // eight captures make a word; the buffer takes it if empty or draining.
  task automatic model_edge(input bit e, input bit qq, input bit c, input bit r);
    logic [7:0] w;
    bit done;
    bit took;
    done = 1'b0;
    took = m_valid && r;
    w = 8'h00;
    if (c) begin
      m_bits.delete();
      m_ovr = 1'b0;
    end else if (m_enp && !e) begin
      m_bits.push_back(qq);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) w[i] = m_bits[i];
        m_bits.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_data  = w;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (took) begin
      m_valid = 1'b0;
    end
    m_enp = e;
  endtask

  task automatic check_all();
    chk("data",  32'(byte_data),  32'(m_data));
    chk("valid", 32'(byte_valid), 32'(m_valid));
    chk("count", 32'(bit_count),  32'(m_bits.size()));
    chk("ovr",   32'(overrun),    32'(m_ovr));
  endtask

  task automatic step(input logic e, input logic qq, input logic c, input logic r);
    en = e; q = qq; clr = c; byte_ready = r;
    @(posedge clk);
    model_edge(e, qq, c, r);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(1)), 1'b0, r);
  endtask

  task automatic close_bit(input logic b, input logic rdy_hi, input logic rdy_cap, input int nhigh);
    for (int i = 0; i < nhigh; i++) step(1'b1, b, 1'b0, rdy_hi);
    step(1'b0, b, 1'b0, rdy_cap);
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy, input logic rdy_last);
    for (int i = 0; i < W; i++) close_bit(w[i], rdy, (i == W-1) ? rdy_last : rdy, 2);
  endtask

  // Asynchronous reset pulse asserted between clock edges.
  task automatic do_reset(input logic e);
    #2;
    reset = 1'b0; en = e; clr = 1'b0; byte_ready = 1'b0;
    #1;
    model_reset();
    chk("rst_data",  32'(byte_data),  32'h0);
    chk("rst_valid", 32'(byte_valid), 32'h0);
    chk("rst_count", 32'(bit_count),  32'h0);
    chk("rst_ovr",   32'(overrun),    32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_all();
  endtask

  initial begin
    logic [7:0] pat;
    bit e_r;
    model_reset();
    #2;
    chk("por_data",  32'(byte_data),  32'h0);
    chk("por_valid", 32'(byte_valid), 32'h0);
    chk("por_count", 32'(bit_count),  32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 1,0,1,1,0,0,1,0 with en toggling every 10 clocks -> 8'h4D
    pat = 8'h4D;
    for (int i = 0; i < W; i++) begin
      close_bit(pat[i], 1'b1, 1'b1, 10);
      if (i < W-1) idle(9, 1'b1);
    end
    chk("r28_valid", 32'(byte_valid), 32'h1);
    chk("r28_data",  32'(byte_data),  32'h4D);
    idle(3, 1'b1);
    chk("r28_drain", 32'(byte_valid), 32'h0);

    // overrun while A5 is pending
    send_word(8'hA5, 1'b0, 1'b0);
    chk("r29_pend", 32'(byte_data), 32'hA5);
    send_word(8'hFF, 1'b0, 1'b0);
    chk("r29_ovr",  32'(overrun),   32'h1);
    chk("r29_keep", 32'(byte_data), 32'hA5);
    idle(1, 1'b1);
    chk("r29_cons", 32'(byte_valid), 32'h0);
    chk("r29_sticky", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("r29_clr", 32'(overrun), 32'h0);

    // completion coincident with consumption
    send_word(8'hA5, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b1);
    chk("r30_data",  32'(byte_data),  32'h3C);
    chk("r30_valid", 32'(byte_valid), 32'h1);
    chk("r30_ovr",   32'(overrun),    32'h0);
    idle(2, 1'b1);

    // reset mid-word, en held high across release
    for (int i = 0; i < 5; i++) close_bit(1'b1, 1'b0, 1'b0, 2);
    do_reset(1'b1);
    chk("r31_count", 32'(bit_count), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("r26_nocap", 32'(bit_count), 32'h0);
    send_word(8'h00, 1'b1, 1'b1);
    chk("r31_valid", 32'(byte_valid), 32'h1);
    chk("r31_data",  32'(byte_data),  32'h00);
    idle(2, 1'b1);
    chk("r31_once", 32'(byte_valid), 32'h0);

    // no capture from q wiggle, rising en or steady en
    for (int i = 0; i < 3; i++) close_bit(1'b1, 1'b0, 1'b0, 2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'(i), 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    chk("r32_hold", 32'(bit_count), 32'h3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("r32_cap", 32'(bit_count), 32'h4);

    // clr on the third capture edge
    do_reset(1'b0);
    close_bit(1'b1, 1'b0, 1'b0, 2);
    close_bit(1'b0, 1'b0, 1'b0, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("r33_count", 32'(bit_count), 32'h0);
    send_word(8'h96, 1'b1, 1'b1);
    chk("r33_valid", 32'(byte_valid), 32'h1);
    chk("r33_data",  32'(byte_data),  32'h96);
    idle(2, 1'b1);
    chk("r33_one", 32'(byte_valid), 32'h0);

    // random traffic
    e_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(599) == 0) begin
        do_reset(1'($urandom_range(1)));
      end else begin
        if ($urandom_range(3) == 0) e_r = !e_r;
        step(e_r, 1'($urandom_range(1)), ($urandom_range(59) == 0),
             ($urandom_range(2) != 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
